fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the single-cycle controller/decoder.
- Owns the PC and issues in-order word requests to instruction memory over a valid/ready request channel with a fixed-order response channel.
- Buffers returned words in a small FIFO and presents the head instruction to decode, already split into op/funct3/funct7.
- Accepts redirects (pc_src/pc_target) from the controller and flushes all stale work.

---
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers words for decode.
// Optional MISALIGN_TRAP_EN: a misaligned redirect sets a sticky error and halts fetch.
module fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            misaligned_err
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [31:0]      data_mem [FIFO_DEPTH];
    logic [XLEN-1:0]  pc_mem   [FIFO_DEPTH];

    logic             running;
    logic [CNT_W:0]   in_flight;
    logic             req_fire;
    logic             push;
    logic             pop;
    logic             unused_low_bits;

`ifdef MISALIGN_TRAP_EN
    typedef enum logic {RUN, HALT} state_e;
    state_e state_q, state_d;
    logic   err_q, err_d;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (pc_src && (pc_target[1:0] != 2'b00)) begin
            state_d = HALT;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign running        = (state_q == RUN);
    assign misaligned_err = err_q;
`else
    assign running        = 1'b1;
    assign misaligned_err = 1'b0;
`endif
    assign unused_low_bits = ^pc_target[1:0];

    // Credits cover both in-flight requests and buffered words, so a response always has a slot.
    assign in_flight      = {1'b0, outst_q} + {1'b0, count_q};
    assign imem_req_valid = running && !rst && (in_flight < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid = (count_q != '0) && !rst;
    assign pop         = instr_valid && instr_ready && !pc_src;
    assign push        = imem_rsp_valid && !pc_src && (discard_q == '0) && running;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        discard_d  = discard_q;
        outst_d    = outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

        if (req_fire)
            fetch_pc_d = fetch_pc_q + XLEN'(4);

        if (pc_src) begin
            fetch_pc_d = {pc_target[XLEN-1:2], 2'b00};
            rsp_pc_d   = {pc_target[XLEN-1:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            // Pending discards are already part of outstanding, so every request still
            // in flight after this edge is stale.
            discard_d  = outst_d;
        end else begin
            if (imem_rsp_valid && (discard_q != '0))
                discard_d = discard_q - CNT_W'(1);
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                rsp_pc_d = rsp_pc_q + XLEN'(4);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    // NOTE: buffer storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_rsp_data;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    assign instr          = instr_valid ? data_mem[rd_ptr_q] : NOP;
    assign instr_pc       = instr_valid ? pc_mem[rd_ptr_q] : '0;
    assign instr_pc_plus4 = instr_pc + XLEN'(4);
    assign op             = instr[6:0];
    assign funct3         = instr[14:12];
    assign funct7         = instr[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: 1-cycle in-order memory model plus a pop-order scoreboard.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        misaligned_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic        rsp_en;
    logic [31:0] pend [$];
    logic [31:0] hold_addr;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .pc_src         (pc_src),
        .pc_target      (pc_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .op             (op),
        .funct3         (funct3),
        .funct7         (funct7),
        .misaligned_err (misaligned_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h00A0_0093 + (a << 20) + (a << 10);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // One clock: scoreboard pops before the edge, then advance the memory model after it.
    task automatic cycle();
        logic        fire;
        logic        rsp;
        logic [31:0] fire_addr;
        logic [31:0] dropped;
        @(negedge clk);
        fire      = imem_req_valid && imem_req_ready;
        fire_addr = imem_req_addr;
        rsp       = imem_rsp_valid;
        if (instr_valid && instr_ready && !pc_src && !rst) begin
            check("pop_pc", instr_pc, exp_pc);
            check("pop_instr", instr, word(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            pend.delete();
        end else begin
            if (rsp && pend.size() != 0) dropped = pend.pop_front();
            if (fire) pend.push_back(fire_addr);
        end
        if (rsp_en && pend.size() != 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(pend[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!instr_valid && n < 20) begin
            cycle();
            n++;
        end
        check({tag, "_timeout"}, {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic redirect(input logic [31:0] target);
        pc_src    = 1'b1;
        pc_target = target;
        cycle();
        pc_src    = 1'b0;
        exp_pc    = {target[31:2], 2'b00};
    endtask

    initial begin
        rst = 1'b1; pc_src = 1'b0; pc_target = '0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        instr_ready = 1'b0; rsp_en = 1'b1; exp_pc = '0;
        run(2);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr_nop", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_err", {31'd0, misaligned_err}, 32'd0);

        // Reset release: first request at 0x0, first word visible two edges later.
        rst = 1'b0; instr_ready = 1'b1;
        #1;
        check("rel_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("rel_req_addr", imem_req_addr, 32'h0);
        cycle();
        check("e1_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("e1_req_addr", imem_req_addr, 32'h4);
        cycle();
        check("e2_instr_valid", {31'd0, instr_valid}, 32'd1);
        check("e2_instr", instr, 32'h00A0_0093);
        check("e2_op", {25'd0, op}, 32'h13);
        check("e2_funct3", {29'd0, funct3}, 32'd0);
        check("e2_funct7", {25'd0, funct7}, 32'd0);
        check("e2_pc", instr_pc, 32'h0);
        check("e2_pc_plus4", instr_pc_plus4, 32'h4);
        check("e2_credit_full", {31'd0, imem_req_valid}, 32'd0);
        cycle();
        check("e3_pc", instr_pc, 32'h4);
        check("e3_instr", instr, 32'h00E0_1093);
        check("e3_funct3", {29'd0, funct3}, 32'd1);
        check("e3_req_addr", imem_req_addr, 32'h8);
        run(8);

        // Decode stall: credits cap in-flight work, nothing lost on resume.
        instr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("stall_inflight", {31'd0, pend.size() <= 2}, 32'd1);
        end
        check("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("stall_head", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        run(8);

        // Redirect with two requests outstanding.
        rsp_en = 1'b0;
        run(5);
        check("outst_two", pend.size(), 32'd2);
        check("outst_empty", {31'd0, instr_valid}, 32'd0);
        redirect(32'h100);
        check("redir_flush", {31'd0, instr_valid}, 32'd0);
        check("redir_addr", imem_req_addr, 32'h100);
        rsp_en = 1'b1;
        wait_valid("redir100");
        check("redir_pc", instr_pc, 32'h100);
        check("redir_instr", instr, 32'h10A4_0093);
        check("redir_funct7", {25'd0, funct7}, 32'h08);
        run(6);

        // Redirect while requests and responses are flowing.
        redirect(32'h200);
        check("flow_flush", {31'd0, instr_valid}, 32'd0);
        wait_valid("redir200");
        check("flow_pc", instr_pc, 32'h200);
        run(6);

        // Memory back-pressure: address held stable.
        begin
            int n = 0;
            while (!imem_req_valid && n < 20) begin
                cycle();
                n++;
            end
            check("hold_wait", {31'd0, imem_req_valid}, 32'd1);
        end
        imem_req_ready = 1'b0;
        hold_addr      = imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("hold_addr", imem_req_addr, hold_addr);
            check("hold_valid", {31'd0, imem_req_valid}, 32'd1);
        end
        imem_req_ready = 1'b1;
        run(6);

        // PC wrap at 2^32.
        redirect(32'hFFFF_FFFC);
        wait_valid("wrap");
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", instr_pc_plus4, 32'h0);
        run(6);

        // Misaligned redirect.
        redirect(32'h102);
`ifdef MISALIGN_TRAP_EN
        check("mis_err", {31'd0, misaligned_err}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("halt_req", {31'd0, imem_req_valid}, 32'd0);
            check("halt_instr", {31'd0, instr_valid}, 32'd0);
        end
`else
        check("mis_err", {31'd0, misaligned_err}, 32'd0);
        wait_valid("mis");
        check("mis_pc", instr_pc, 32'h100);
        run(4);
`endif

        // Reset mid-operation.
        rst = 1'b1;
        cycle();
        check("mrst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("mrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("mrst_instr", instr, 32'h0000_0013);
        check("mrst_err", {31'd0, misaligned_err}, 32'd0);
        rst    = 1'b0;
        exp_pc = '0;
        #1;
        check("mrst_addr", imem_req_addr, 32'h0);
        wait_valid("mrst");
        check("mrst_pc", instr_pc, 32'h0);
        run(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
